i2s_audio_tx: RTL
=================

// Module: i2s_audio_tx
// PURPOSE
//  I2S master transmitter for the stereo DAC. Sits downstream of the zxuno core audio mixer.
//  Takes two 16-bit PCM words and produces MCLK, SCLK, LRCK and SDIN for the board codec.
//  Runs entirely on the system clock; all codec clocks are derived by counters, with no PLL.
//  Frame = 64 SCLK (two 32-bit slots); fs = f_clk/512 (54687.5 Hz at 28 MHz).
// PARAMETERS
//  DW        16  sample width; MSB-first, left-justified in each 32-bit slot, remaining slot bits 0
//  MCLK_DIV   2  clk cycles per MCLK period (MCLK = 256*fs); fixed, documented for checks only
//  SCLK_DIV   8  clk cycles per SCLK period; fixed
// PORTS
//  clk        in   1   system clock (28 MHz in the UAReloaded build)
//  rst        in   1   synchronous, active-high reset
//  enable     in   1   run request; sampled only at frame boundaries
//  left_in    in   DW  left sample, two's complement, forwarded unmodified
//  right_in   in   DW  right sample, two's complement, forwarded unmodified
//  sample_req out  1   one-clk pulse on the cycle left_in/right_in are captured
//  busy       out  1   high while a frame is being transmitted
//  mclk       out  1   codec master clock, clk/2
//  sclk       out  1   bit clock, clk/8, 50% duty
//  lrck       out  1   word select: 0 = left slot, 1 = right slot
//  sdin       out  1   serial data to the codec
// BEHAVIOUR
//  Reset: all outputs 0; d=0, n=0, shift register 0, state IDLE.
//  mclk toggles every clk from the first cycle after reset, independent of enable.
//  d = 3-bit phase counter, n = 6-bit slot counter. d runs only in RUN and is held at 0 in IDLE.
//  sclk = d[2], registered. It rises on the 3->4 transition and falls on the 7->0 transition.
//  All lrck/sdin/n updates happen only on the clk where d wraps 7->0 (the SCLK falling edge).
//  Codec samples on the SCLK rising edge. Data is stable 4 clks before and 4 clks after that edge.
//  States:
//   IDLE: d=0, sclk/lrck/sdin held 0, busy=0.
//    If enable=1: capture inputs, pulse sample_req, n=0, go to RUN.
//    This is a frame boundary, so the first SCLK fall happens 8 clks later.
//   RUN: busy=1.
//    Slot n carries: n=0 -> 0 (trailing pad); n=1..16 -> L[15..0]; n=17..32 -> 0;
//    n=33..48 -> R[15..0]; n=49..63 -> 0.
//    lrck = n[5], which gives the I2S 1-bit delay (MSB one SCLK after lrck edge).
//   Frame end (n=63 and d wraps):
//    If enable=1: n->0, capture new inputs, pulse sample_req on the same clk. No gap between frames.
//    If enable=0: go to IDLE; sclk, lrck, sdin -> 0 on that clk.
//  enable is ignored mid-frame; a deassert always completes the current frame.
//  Inputs may change at any time; only the value on the sample_req clk is transmitted.
//  Holding/double-buffer: captured words persist for the whole frame.
//  sample_req period in RUN is exactly 512 clks.
//  rst mid-frame: all outputs go to 0 on the next clk and state is IDLE. No partial-frame completion.
// TESTING
//  1. Reset, enable=0, 2000 clks: mclk toggles every clk; sclk, lrck, sdin, busy, sample_req stay 0.
//  2. L=16'hA5C3, R=16'h1234, enable=1:
//     sample_req pulses once; decoded SCLK-rising bits 1..16 = A5C3 with lrck=0;
//     bits 33..48 = 1234 with lrck=1; all pad bits 0.
//  3. Continuous run: sample_req spacing 512 clks; sclk period 8 clks, high 4;
//     lrck period 512 clks, high 256; no glitch at the frame seam.
//  4. Change L/R 3 clks after sample_req (L=16'h8000 -> 16'h7FFF): the current frame still sends 8000;
//     the next frame sends 7FFF.
//  5. Drop enable at n=20: frame completes through n=63; busy falls 512 clks after the last sample_req;
//     outputs 0; re-assert restarts with n=0.
//  6. Assert rst at n=40 with data 16'hFFFF: next clk sclk=lrck=sdin=busy=0;
//     after release with enable=1 the first frame is clean.

Source files
------------

// File: rtl/i2s_audio_tx.sv
// I2S master transmitter: 16-bit stereo PCM to MCLK/SCLK/LRCK/SDIN, all clocks divided from clk.
// Latency: first SCLK fall 8 clks after capture; frame = 512 clks; no backpressure, inputs sampled on sample_req.
module i2s_audio_tx #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [DW-1:0] left_in,
    input  logic [DW-1:0] right_in,
    output logic          sample_req,
    output logic          busy,
    output logic          mclk,
    output logic          sclk,
    output logic          lrck,
    output logic          sdin
);
    localparam int PAD = 31 - DW;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t      state_q;
    logic [2:0]  d_q;
    logic [5:0]  n_q;
    logic [63:0] sr_q;
    logic        mclk_q, sclk_q, lrck_q, sdin_q, busy_q, req_q;

    logic [2:0]  d_d;
    logic [5:0]  n_d;
    logic [63:0] load_d;

    assign d_d = d_q + 3'd1;
    assign n_d = n_q + 6'd1;
    // Slot 0 of each half is the I2S one-bit delay; words sit MSB-first right after it.
    assign load_d = {1'b0, left_in, {PAD{1'b0}}, 1'b0, right_in, {PAD{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            n_q     <= '0;
            sr_q    <= '0;
            mclk_q  <= 1'b0;
            sclk_q  <= 1'b0;
            lrck_q  <= 1'b0;
            sdin_q  <= 1'b0;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            mclk_q <= ~mclk_q;
            req_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    d_q    <= '0;
                    sclk_q <= 1'b0;
                    lrck_q <= 1'b0;
                    sdin_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (enable) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        n_q     <= '0;
                        sr_q    <= load_d;
                        req_q   <= 1'b1;
                    end
                end
                S_RUN: begin
                    d_q    <= d_d;
                    sclk_q <= d_d[2];
                    // Data and word select only move on the SCLK falling edge.
                    if (d_q == 3'd7) begin
                        if (n_q == 6'd63) begin
                            n_q    <= '0;
                            lrck_q <= 1'b0;
                            sdin_q <= 1'b0;
                            if (enable) begin
                                sr_q  <= load_d;
                                req_q <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            n_q    <= n_d;
                            lrck_q <= n_d[5];
                            sdin_q <= sr_q[62];
                            sr_q   <= {sr_q[62:0], 1'b0};
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sample_req = req_q;
    assign busy       = busy_q;
    assign mclk       = mclk_q;
    assign sclk       = sclk_q;
    assign lrck       = lrck_q;
    assign sdin       = sdin_q;
endmodule
